// File: rtl/audio_player.sv
// audio_player: streams a contiguous range of samples from a word-addressed
// memory to a codec. One read is in flight at a time. Each codec request
// either takes the held sample or, on underrun or pause, gets silence.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for play_start; range checked and latched here
// FETCH   | issue one read strobe for the current address
// WAIT    | waiting for read data; a stop here is remembered as pending
// HOLD    | sample held; next codec request consumes it (unless paused)
// DONE    | one-cycle play_done pulse
// RELEASE | waiting for play_start to drop before re-arming
module audio_player #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              play_start,
    input  logic [ADDR_W-1:0] play_select,
    input  logic [ADDR_W-1:0] play_end,
    input  logic              play_pause,
    input  logic              play_stop,
    output logic              play_done,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_valid,
    input  logic              i_dac_req,
    output logic [DATA_W-1:0] o_dac_data,
    output logic              o_dac_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] end_addr;
    logic [DATA_W-1:0] sample;
    logic              pending;
    logic              abort;

    // Controller withdrawing the request is treated exactly like a stop.
    assign abort = play_stop | ~play_start;

    // Playback sequencer with all outputs registered; outputs default to
    // idle each cycle so strobes are single-cycle by construction.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            addr        <= '0;
            end_addr    <= '0;
            sample      <= '0;
            pending     <= 1'b0;
            play_done   <= 1'b0;
            o_mem_rd    <= 1'b0;
            o_mem_addr  <= '0;
            o_dac_data  <= '0;
            o_dac_valid <= 1'b0;
        end else begin
            play_done   <= 1'b0;
            o_mem_rd    <= 1'b0;
            o_dac_valid <= 1'b0;
            o_dac_data  <= '0;
            // Outside HOLD a codec request is an underrun: answer with silence.
            if (i_dac_req && state != S_HOLD) begin
                o_dac_valid <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    pending <= 1'b0;
                    if (play_start) begin
                        if (play_select < play_end) begin
                            addr     <= play_select;
                            end_addr <= play_end;
                            state    <= S_FETCH;
                        end else begin
                            play_done <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_FETCH: begin
                    if (abort) begin
                        play_done <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        o_mem_rd   <= 1'b1;
                        o_mem_addr <= addr;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // The read cannot be cancelled, so a stop waits for the
                    // return and throws the data away.
                    if (i_mem_valid) begin
                        if (pending || abort) begin
                            pending   <= 1'b0;
                            play_done <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            sample <= i_mem_rdata;
                            addr   <= addr + ADDR_W'(1);
                            state  <= S_HOLD;
                        end
                    end else if (abort) begin
                        pending <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (abort) begin
                        // Codec still gets its strobe, but only silence.
                        o_dac_valid <= i_dac_req;
                        play_done   <= 1'b1;
                        state       <= S_DONE;
                    end else if (i_dac_req) begin
                        o_dac_valid <= 1'b1;
                        if (!play_pause) begin
                            o_dac_data <= sample;
                            if (addr == end_addr) begin
                                play_done <= 1'b1;
                                state     <= S_DONE;
                            end else begin
                                state <= S_FETCH;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!play_start) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_player.sv
// Directed bench for audio_player: a simple fixed-latency memory model and a
// codec request generator are advanced one cycle at a time by step().
module tb_audio_player;

    localparam int AW = 23;
    localparam int DW = 16;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          play_start;
    logic [AW-1:0] play_select;
    logic [AW-1:0] play_end;
    logic          play_pause;
    logic          play_stop;
    logic          play_done;
    logic          o_mem_rd;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] i_mem_rdata;
    logic          i_mem_valid;
    logic          i_dac_req;
    logic [DW-1:0] o_dac_data;
    logic          o_dac_valid;

    audio_player #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .play_start  (play_start),
        .play_select (play_select),
        .play_end    (play_end),
        .play_pause  (play_pause),
        .play_stop   (play_stop),
        .play_done   (play_done),
        .o_mem_rd    (o_mem_rd),
        .o_mem_addr  (o_mem_addr),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_valid (i_mem_valid),
        .i_dac_req   (i_dac_req),
        .o_dac_data  (o_dac_data),
        .o_dac_valid (o_dac_valid)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] rd_log[$];
    logic [DW-1:0] smp_log[$];
    int            zero_cnt;
    int            done_cnt;
    int            mem_cnt;
    int            mem_lat;
    int            dac_period;
    int            dac_cnt;
    logic [AW-1:0] mem_addr;

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return a[15:0] ^ 16'h5A00;
    endfunction

    task automatic clear_logs();
        rd_log.delete();
        smp_log.delete();
        zero_cnt = 0;
        done_cnt = 0;
    endtask

    // One clock: observe outputs just after the edge, then update the memory
    // model and the codec request for the next edge.
    task automatic step();
        @(posedge i_clk);
        #1;
        if (o_mem_rd) rd_log.push_back(o_mem_addr);
        if (o_dac_valid) begin
            if (o_dac_data == '0) zero_cnt++;
            else smp_log.push_back(o_dac_data);
        end
        if (play_done) done_cnt++;
        i_mem_valid = 1'b0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                i_mem_valid = 1'b1;
                i_mem_rdata = mem_fn(mem_addr);
            end
        end
        if (o_mem_rd) begin
            mem_cnt  = mem_lat;
            mem_addr = o_mem_addr;
        end
        i_dac_req = 1'b0;
        if (dac_period > 0) begin
            if (dac_cnt >= dac_period - 1) begin
                dac_cnt   = 0;
                i_dac_req = 1'b1;
            end else begin
                dac_cnt++;
            end
        end
    endtask

    task automatic run_until_done(input string name, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        n_checks++;
        if (done_cnt == 0) begin
            n_fail++;
            $display("FAIL %s: play_done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        play_start = 0; play_select = '0; play_end = '0;
        play_pause = 0; play_stop = 0;
        i_mem_rdata = '0; i_mem_valid = 0; i_dac_req = 0;
        mem_cnt = 0; mem_lat = 2; dac_period = 0; dac_cnt = 0;
        repeat (3) step();
        i_dac_req = 1'b1;
        i_mem_valid = 1'b1;
        i_mem_rdata = 16'hFFFF;
        step();
        n_checks++; if (play_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", play_done); end
        n_checks++; if (o_mem_rd !== 1'b0) begin n_fail++; $display("FAIL rst_rd: got %b want 0", o_mem_rd); end
        n_checks++; if (o_mem_addr !== '0) begin n_fail++; $display("FAIL rst_addr: got %0h want 0", o_mem_addr); end
        n_checks++; if (o_dac_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dac_valid: got %b want 0", o_dac_valid); end
        n_checks++; if (o_dac_data !== '0) begin n_fail++; $display("FAIL rst_dac_data: got %0h want 0", o_dac_data); end
        i_mem_valid = 1'b0;
        i_rst = 1'b0;
        step();
        clear_logs();
    endtask

    task automatic test_play();
        clear_logs();
        mem_lat = 2; dac_period = 10; dac_cnt = 0;
        play_select = 23'h100; play_end = 23'h103; play_start = 1'b1;
        run_until_done("play_timeout", 400);
        play_start = 1'b0;
        repeat (4) step();
        n_checks++; if (rd_log.size() != 3) begin n_fail++; $display("FAIL play_rd_count: got %0d want 3", rd_log.size()); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= rd_log.size() || rd_log[i] !== 23'h100 + AW'(i)) begin
                n_fail++; $display("FAIL play_rd_addr[%0d]: got %0h want %0h", i, (i < rd_log.size()) ? rd_log[i] : '0, 23'h100 + AW'(i));
            end
            n_checks++;
            if (i >= smp_log.size() || smp_log[i] !== mem_fn(23'h100 + AW'(i))) begin
                n_fail++; $display("FAIL play_sample[%0d]: got %0h want %0h", i, (i < smp_log.size()) ? smp_log[i] : '0, mem_fn(23'h100 + AW'(i)));
            end
        end
        n_checks++; if (smp_log.size() != 3) begin n_fail++; $display("FAIL play_sample_count: got %0d want 3", smp_log.size()); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL play_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_empty();
        clear_logs();
        dac_period = 0;
        play_select = 23'h200; play_end = 23'h200; play_start = 1'b1;
        step();
        n_checks++; if (play_done !== 1'b1) begin n_fail++; $display("FAIL empty_done_latency: got %b want 1", play_done); end
        repeat (4) step();
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL empty_done_count: got %0d want 1", done_cnt); end
        n_checks++; if (rd_log.size() != 0) begin n_fail++; $display("FAIL empty_no_read: got %0d reads want 0", rd_log.size()); end
        n_checks++; if (smp_log.size() != 0) begin n_fail++; $display("FAIL empty_no_sample: got %0d want 0", smp_log.size()); end
        play_start = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_pause();
        clear_logs();
        mem_lat = 1; dac_period = 0;
        play_select = 23'h300; play_end = 23'h302; play_start = 1'b1;
        repeat (8) step();
        play_pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_dac_req = 1'b1;
            repeat (3) step();
        end
        n_checks++; if (zero_cnt != 3) begin n_fail++; $display("FAIL pause_zero_count: got %0d want 3", zero_cnt); end
        n_checks++; if (smp_log.size() != 0) begin n_fail++; $display("FAIL pause_no_sample: got %0d want 0", smp_log.size()); end
        play_pause = 1'b0;
        i_dac_req = 1'b1;
        repeat (2) step();
        n_checks++;
        if (smp_log.size() != 1 || smp_log[0] !== 16'h5900) begin
            n_fail++; $display("FAIL pause_resume_sample: got %0d samples, first %0h want 1 sample 5900", smp_log.size(), (smp_log.size() > 0) ? smp_log[0] : '0);
        end
        dac_period = 5; dac_cnt = 0;
        run_until_done("pause_timeout", 200);
        n_checks++;
        if (smp_log.size() != 2 || smp_log[1] !== 16'h5901) begin
            n_fail++; $display("FAIL pause_second_sample: got %0d samples, last %0h want 2 samples ending 5901", smp_log.size(), (smp_log.size() > 1) ? smp_log[1] : '0);
        end
        play_start = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_stop_wait();
        int n = 0;
        clear_logs();
        mem_lat = 4; dac_period = 3; dac_cnt = 0;
        play_select = 23'h400; play_end = 23'h404; play_start = 1'b1;
        while (rd_log.size() == 0 && n < 20) begin step(); n++; end
        n_checks++; if (rd_log.size() != 1) begin n_fail++; $display("FAIL stop_read_seen: got %0d reads want 1", rd_log.size()); end
        play_stop = 1'b1;
        n = 0;
        while (!i_mem_valid && n < 20) begin step(); n++; end
        n_checks++; if (i_mem_valid !== 1'b1) begin n_fail++; $display("FAIL stop_valid_timeout: no read return within 20 cycles"); end
        step();
        n_checks++; if (play_done !== 1'b1) begin n_fail++; $display("FAIL stop_done_after_valid: got %b want 1", play_done); end
        repeat (5) step();
        n_checks++; if (smp_log.size() != 0) begin n_fail++; $display("FAIL stop_data_discarded: got %0d samples want 0", smp_log.size()); end
        n_checks++; if (rd_log.size() != 1) begin n_fail++; $display("FAIL stop_no_more_reads: got %0d want 1", rd_log.size()); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL stop_done_count: got %0d want 1", done_cnt); end
        play_start = 1'b0; play_stop = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_back_to_back();
        clear_logs();
        mem_lat = 1; dac_period = 4; dac_cnt = 0;
        play_select = 23'h500; play_end = 23'h501; play_start = 1'b1;
        run_until_done("b2b_first_timeout", 100);
        repeat (5) step();
        n_checks++; if (rd_log.size() != 1) begin n_fail++; $display("FAIL b2b_no_retrigger: got %0d reads want 1", rd_log.size()); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL b2b_single_done: got %0d want 1", done_cnt); end
        play_start = 1'b0;
        step();
        clear_logs();
        play_select = 23'h510; play_end = 23'h512; play_start = 1'b1;
        repeat (2) step();
        play_select = 23'h7000; play_end = 23'h7FFF;
        run_until_done("b2b_second_timeout", 200);
        play_start = 1'b0;
        repeat (3) step();
        n_checks++;
        if (rd_log.size() != 2 || rd_log[0] !== 23'h510 || rd_log[1] !== 23'h511) begin
            n_fail++; $display("FAIL b2b_latched_range: got %0d reads want 510,511", rd_log.size());
        end
        n_checks++;
        if (smp_log.size() != 2 || smp_log[0] !== 16'h5F10 || smp_log[1] !== 16'h5F11) begin
            n_fail++; $display("FAIL b2b_samples: got %0d samples want 5f10,5f11", smp_log.size());
        end
    endtask

    task automatic test_reset_hold();
        clear_logs();
        mem_lat = 1; dac_period = 0;
        play_select = 23'h600; play_end = 23'h602; play_start = 1'b1;
        repeat (8) step();
        i_rst = 1'b1;
        play_start = 1'b0;
        i_dac_req = 1'b1;
        step();
        n_checks++; if (o_dac_valid !== 1'b0 || o_dac_data !== '0) begin n_fail++; $display("FAIL rsthold_dac: got valid %b data %0h want 0 0", o_dac_valid, o_dac_data); end
        n_checks++; if (o_mem_rd !== 1'b0 || o_mem_addr !== '0) begin n_fail++; $display("FAIL rsthold_mem: got rd %b addr %0h want 0 0", o_mem_rd, o_mem_addr); end
        n_checks++; if (play_done !== 1'b0) begin n_fail++; $display("FAIL rsthold_done: got %b want 0", play_done); end
        i_rst = 1'b0;
        step();
        i_dac_req = 1'b1;
        step();
        n_checks++; if (o_dac_valid !== 1'b1 || o_dac_data !== '0) begin n_fail++; $display("FAIL rsthold_idle_silence: got valid %b data %0h want 1 0", o_dac_valid, o_dac_data); end
        repeat (3) step();
        n_checks++; if (done_cnt != 0 || smp_log.size() != 0) begin n_fail++; $display("FAIL rsthold_no_done: got done %0d samples %0d want 0 0", done_cnt, smp_log.size()); end
    endtask

    initial begin
        test_reset();
        test_play();
        test_empty();
        test_pause();
        test_stop_wait();
        test_back_to_back();
        test_reset_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
